// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: in-order instruction fetch feeding a DEPTH-entry {pc,inst} prefetch FIFO, flushed on redirect.
// Optional FETCH_STATS_EN adds saturating stat_fetched/stat_dropped counters.
module riscv_fetch_queue #(
   parameter int                   BUS_WIDTH = 32,
   parameter int                   DEPTH     = 4,
   parameter int                   PC_STEP   = 1,
   parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [BUS_WIDTH-1:0] imem_addr,
   input  logic                 imem_gnt,
   input  logic                 imem_rvalid,
   input  logic [BUS_WIDTH-1:0] imem_rdata,
   input  logic                 redirect,
   input  logic [BUS_WIDTH-1:0] redirect_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] out_inst,
   output logic [BUS_WIDTH-1:0] out_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]          stat_fetched,
   output logic [31:0]          stat_dropped
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(PC_STEP);
   logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [BUS_WIDTH-1:0] pc_mem_q [DEPTH];
   logic [BUS_WIDTH-1:0] inst_mem_q [DEPTH];
   logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]        count_q, count_d, outs_q, outs_d, disc_q, disc_d;
   logic [CW:0]          credit;
   logic                 grant, rv, push, pop;

   // buffered plus in-flight fetches never exceed DEPTH, so the FIFO cannot overflow
   assign credit    = {1'b0, count_q} + {1'b0, outs_q};
   assign imem_req  = !reset && !redirect && (credit < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc_q;
   assign grant     = imem_req && imem_gnt;
   assign rv        = imem_rvalid && (outs_q != '0);
   assign push      = rv && !redirect && (disc_q == '0);
   assign out_valid = count_q != '0;
   assign pop       = out_valid && out_ready && !redirect;
   assign out_inst  = inst_mem_q[rd_q];
   assign out_pc    = pc_mem_q[rd_q];

   // next state; redirect overrides push, pop and grant and turns every in-flight response into a discard
   always_comb begin
      fetch_pc_d = redirect ? redirect_pc : grant ? fetch_pc_q + STEP : fetch_pc_q;
      resp_pc_d  = redirect ? redirect_pc : push ? resp_pc_q + STEP : resp_pc_q;
      outs_d     = outs_q + CW'(grant) - CW'(rv);
      disc_d     = redirect ? outs_q - CW'(rv) : disc_q - CW'(rv && (disc_q != '0));
      count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
      rd_d       = redirect ? '0 : rd_q + AW'(pop);
      wr_d       = redirect ? '0 : wr_q + AW'(push);
   end

   // state registers and FIFO storage
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         outs_q     <= '0;
         disc_q     <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outs_q     <= outs_d;
         disc_q     <= disc_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         if (push) begin
            pc_mem_q[wr_q]   <= resp_pc_q;
            inst_mem_q[wr_q] <= imem_rdata;
         end
      end
   end

`ifdef FETCH_STATS_EN
   // saturating counts of instructions handed to the decoder and of responses thrown away
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetched <= '0;
         stat_dropped <= '0;
      end else begin
         if (pop && (stat_fetched != '1)) stat_fetched <= stat_fetched + 32'd1;
         if (rv && (redirect || (disc_q != '0)) && (stat_dropped != '1)) stat_dropped <= stat_dropped + 32'd1;
      end
   end
`endif

   rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> (outs_q != '0));

endmodule
